expr_stream_checker: RTL and testbench
======================================

// Module: expr_stream_checker
// PURPOSE
//  Streaming syntax checker for arithmetic expressions, one ASCII character per accepted cycle.
//  Successor to the single-digit num/op recogniser. Adds:
//   - multi-digit operands
//   - a configurable operator set
//   - parenthesis nesting up to a parameterised depth
//   - an input-valid qualifier
//   - a sticky error flag
//  Sits after the UART/char front end. out=1 whenever the prefix received so far is a complete, legal expression.
// PARAMETERS
//  MAX_DEPTH   4  maximum parenthesis nesting depth (>=1)
//  MAX_DIGITS  3  maximum digits per operand (>=1)
//  EXT_OPS     0  0: operators '+','*' only; 1: also '-','/'
// PORTS
//  clk        in   1   clock, rising edge
//  clr        in   1   asynchronous active-high reset
//  in_valid   in   1   in is consumed on a clk edge only when 1
//  in         in   8   ASCII character
//  out        out  1   accepted prefix is a complete legal expression
//  err        out  1   sticky syntax error; cleared only by clr
//  depth      out  DW  current open-paren count, DW=$clog2(MAX_DEPTH+1)
// BEHAVIOUR
//  Reset (clr=1, async): state=S_START, depth=0, dcnt=0 -> out=0, err=0, depth=0.
//  in_valid=0: all state holds. Space (8'h20) with in_valid=1 is ignored: no state/counter change.
//  Classes:
//   - DIG: '0'..'9'
//   - OP:  '+','*', plus '-','/' iff EXT_OPS=1
//   - LP:  '('
//   - RP:  ')'
//   - any other character -> S_ERR
//  States (2-bit+), next-state registered on posedge clk:
//   S_START: expect operand
//     - DIG -> S_NUM, dcnt=1
//     - LP  -> depth<MAX_DEPTH ? depth+1, stay S_START : S_ERR
//     - else -> S_ERR
//   S_NUM: inside an operand
//     - DIG -> dcnt<MAX_DIGITS and first digit not '0' ? dcnt+1 : S_ERR (no leading zeros)
//     - OP  -> S_OPND, dcnt=0
//     - RP  -> depth>0 ? depth-1, S_CLOSE : S_ERR
//     - else -> S_ERR
//   S_OPND: after an operator; same rules as S_START.
//   S_CLOSE: after ')'
//     - OP  -> S_OPND
//     - RP  -> depth>0 ? depth-1, stay : S_ERR
//     - DIG / LP -> S_ERR
//   S_ERR: absorbing; ignores all input until clr.
//  Outputs are Moore, decoded from registered state, valid the cycle after the edge that consumed the char:
//   - out = (state==S_NUM || state==S_CLOSE) && depth==0
//   - err = (state==S_ERR)
//  Entering S_ERR clears depth and dcnt to 0.
//  Boundaries:
//   - depth saturation: LP at depth==MAX_DEPTH -> err
//   - RP at depth 0 -> err
//   - MAX_DIGITS+1th digit -> err
//   - lone "0" is legal; "0" followed by DIG -> err
//  clr asserted mid-expression: immediate return to reset values, independent of clk.
//  clr has priority over in_valid on the same edge.
//  dcnt width: $clog2(MAX_DIGITS+1). Track first-digit-zero with a 1-bit flag.
// TESTING (defaults unless noted)
//  "12+3*45" with in_valid=1: out sequence 1,1,0,1,0,1,1; err stays 0.
//  "((7+8)*9)": out=1 only after the final ')'; depth steps 1,2,2,2,2,1,1,1,0.
//  "1234" -> err=1 on the 4th char; later "+5" leaves err=1 and out=0.
//  "(((((1" -> err on the 5th '('. With MAX_DEPTH=5, the same input gives no err, out=0, depth=5.
//  Inputs to run:
//   - "07" -> err
//   - "1-2" with EXT_OPS=0 -> err
//   - "1-2" with EXT_OPS=1 -> out=1
//   - "3 + 4" with spaces -> out=1
//   - "3+" with in_valid=0 gaps between chars -> out=0, state held
//  Async clr: pulse clr between clk edges mid "(1+" -> out=0, err=0, depth=0 immediately; then "5" -> out=1.

Source files
------------

// File: rtl/expr_stream_checker.sv
// Streaming arithmetic-expression syntax checker.
// Consumes one ASCII char per valid cycle; Moore out/err/depth.
module expr_stream_checker #(
  parameter int MAX_DEPTH  = 4,
  parameter int MAX_DIGITS = 3,
  parameter int EXT_OPS    = 0,
  localparam int DW = $clog2(MAX_DEPTH + 1),
  localparam int CW = $clog2(MAX_DIGITS + 1)
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          in_valid,
  input  logic [7:0]    in,
  output logic          out,
  output logic          err,
  output logic [DW-1:0] depth
);

  localparam logic [DW-1:0] DMAX = DW'(MAX_DEPTH);
  localparam logic [CW-1:0] CMAX = CW'(MAX_DIGITS);

  typedef enum logic [2:0] {
    S_START,
    S_NUM,
    S_OPND,
    S_CLOSE,
    S_ERR
  } state_t;

  state_t        st_q, st_d;
  logic [DW-1:0] dep_q, dep_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          zero_q, zero_d;

  logic is_dig, is_op, is_lp, is_rp;
  logic take, bad;

  assign take   = in_valid && (in != 8'h20);
  assign is_dig = (in >= 8'h30) && (in <= 8'h39);
  assign is_lp  = (in == 8'h28);
  assign is_rp  = (in == 8'h29);
  assign is_op  = (in == 8'h2B) || (in == 8'h2A) ||
                  ((EXT_OPS != 0) &&
                   ((in == 8'h2D) || (in == 8'h2F)));

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      st_q   <= S_START;
      dep_q  <= '0;
      dcnt_q <= '0;
      zero_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      dep_q  <= dep_d;
      dcnt_q <= dcnt_d;
      zero_q <= zero_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    dep_d  = dep_q;
    dcnt_d = dcnt_q;
    zero_d = zero_q;
    bad    = 1'b0;
    if (take) begin
      unique case (st_q)
        S_START, S_OPND: begin
          unique case (1'b1)
            is_dig: begin
              st_d   = S_NUM;
              dcnt_d = CW'(1);
              zero_d = (in == 8'h30);
            end
            is_lp: begin
              if (dep_q < DMAX) dep_d = dep_q + 1'b1;
              else bad = 1'b1;
            end
            default: bad = 1'b1;
          endcase
        end
        S_NUM: begin
          unique case (1'b1)
            is_dig: begin
              // a leading '0' must stand alone
              if (dcnt_q < CMAX && !zero_q)
                dcnt_d = dcnt_q + 1'b1;
              else
                bad = 1'b1;
            end
            is_op: begin
              st_d   = S_OPND;
              dcnt_d = '0;
              zero_d = 1'b0;
            end
            is_rp: begin
              if (dep_q != '0) begin
                dep_d  = dep_q - 1'b1;
                st_d   = S_CLOSE;
                dcnt_d = '0;
                zero_d = 1'b0;
              end else begin
                bad = 1'b1;
              end
            end
            default: bad = 1'b1;
          endcase
        end
        S_CLOSE: begin
          unique case (1'b1)
            is_op: st_d = S_OPND;
            is_rp: begin
              if (dep_q != '0) dep_d = dep_q - 1'b1;
              else bad = 1'b1;
            end
            default: bad = 1'b1;
          endcase
        end
        S_ERR: ;
        default: bad = 1'b1;
      endcase
    end
    if (bad) begin
      st_d   = S_ERR;
      dep_d  = '0;
      dcnt_d = '0;
      zero_d = 1'b0;
    end
  end

  assign out   = ((st_q == S_NUM) || (st_q == S_CLOSE)) &&
                 (dep_q == '0);
  assign err   = (st_q == S_ERR);
  assign depth = dep_q;

endmodule

// File: tb/tb_expr_stream_checker.sv
// Scoreboard bench for expr_stream_checker: two parameterisations
// driven by one char stream, checked against a grammar-level model.
module tb_expr_stream_checker;

  typedef struct {
    logic o;
    logic e;
    int   d;
  } exp_t;

  logic       clk = 1'b0;
  logic       clr = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in = 8'h00;

  logic       out_a, err_a, out_b, err_b;
  logic [2:0] depth_a, depth_b;

  int n_chk = 0;
  int n_pass = 0;

  byte  hist_a[$];
  byte  hist_b[$];
  exp_t sb_a[$];
  exp_t sb_b[$];

  expr_stream_checker u_a (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out_a), .err(err_a), .depth(depth_a)
  );

  expr_stream_checker #(
    .MAX_DEPTH(5), .MAX_DIGITS(3), .EXT_OPS(1)
  ) u_b (
    .clk(clk), .clr(clr), .in_valid(in_valid), .in(in),
    .out(out_b), .err(err_b), .depth(depth_b)
  );

  always #5 clk = ~clk;

  // Grammar view: tokens are numbers, operators and parens.
  // prev: 0 nothing/op/'(' (operand expected), 1 digit, 2 ')'.
  function automatic exp_t model(input byte h[$], input int maxd,
                                 input bit ext);
    exp_t r;
    int prev = 0;
    int run = 0;
    byte first = 0;
    bit e = 0;
    int d = 0;
    foreach (h[i]) begin
      byte c = h[i];
      if (c >= 8'h30 && c <= 8'h39) begin
        if (prev == 2) e = 1;
        else if (prev == 1) begin
          if (run >= 3 || first == 8'h30) e = 1;
          else run++;
        end else begin
          run = 1;
          first = c;
        end
        prev = 1;
      end else if (c == 8'h2B || c == 8'h2A ||
                   (ext && (c == 8'h2D || c == 8'h2F))) begin
        if (prev == 0) e = 1;
        prev = 0;
      end else if (c == 8'h28) begin
        if (prev != 0 || d >= maxd) e = 1;
        else d++;
        prev = 0;
      end else if (c == 8'h29) begin
        if (prev == 0 || d == 0) e = 1;
        else d--;
        prev = 2;
      end else begin
        e = 1;
      end
      if (e) break;
    end
    r.e = e;
    r.d = e ? 0 : d;
    r.o = !e && (prev != 0) && (d == 0);
    return r;
  endfunction

  task automatic chk(input string nm, input int got, input int want);
    n_chk++;
    if (got == want) n_pass++;
    else $display("FAIL %s: got %0d, want %0d", nm, got, want);
  endtask

  always @(negedge clk) begin
    if (sb_a.size() > 0) begin
      exp_t x;
      x = sb_a.pop_front();
      chk("a.out", int'(out_a), int'(x.o));
      chk("a.err", int'(err_a), int'(x.e));
      chk("a.depth", int'(depth_a), x.d);
    end
    if (sb_b.size() > 0) begin
      exp_t x;
      x = sb_b.pop_front();
      chk("b.out", int'(out_b), int'(x.o));
      chk("b.err", int'(err_b), int'(x.e));
      chk("b.depth", int'(depth_b), x.d);
    end
  end

  task automatic send(input byte c, input bit v);
    @(negedge clk);
    in_valid = v;
    in = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    if (v && c != 8'h20) begin
      hist_a.push_back(c);
      hist_b.push_back(c);
    end
    sb_a.push_back(model(hist_a, 4, 0));
    sb_b.push_back(model(hist_b, 5, 1));
  endtask

  task automatic send_str(input string s, input bit gaps);
    for (int i = 0; i < s.len(); i++) begin
      send(s[i], 1'b1);
      if (gaps) send(8'h37, 1'b0);
    end
  endtask

  task automatic pulse_clr();
    @(negedge clk);
    #2;
    clr = 1'b1;
    #1;
    chk("clr.a.out", int'(out_a), 0);
    chk("clr.a.err", int'(err_a), 0);
    chk("clr.a.depth", int'(depth_a), 0);
    chk("clr.b.depth", int'(depth_b), 0);
    hist_a.delete();
    hist_b.delete();
    #1;
    clr = 1'b0;
  endtask

  task automatic now_a(input string nm, input int o, input int e);
    chk({nm, ".out"}, int'(out_a), o);
    chk({nm, ".err"}, int'(err_a), e);
  endtask

  initial begin
    string pool;
    #2;
    chk("rst.out", int'(out_a), 0);
    chk("rst.err", int'(err_a), 0);
    chk("rst.depth", int'(depth_a), 0);
    @(negedge clk);
    clr = 1'b0;

    send_str("12+3*45", 0);
    now_a("expr", 1, 0);
    pulse_clr();
    send_str("((7+8)*9)", 0);
    now_a("nest", 1, 0);
    pulse_clr();
    send_str("1234+5", 0);
    now_a("digits", 0, 1);
    pulse_clr();
    send_str("(((((1", 0);
    now_a("deep", 0, 1);
    chk("deep.b.err", int'(err_b), 0);
    chk("deep.b.depth", int'(depth_b), 5);
    pulse_clr();
    send_str("07", 0);
    now_a("lead0", 0, 1);
    pulse_clr();
    send_str("0", 0);
    now_a("zero", 1, 0);
    pulse_clr();
    send_str("1-2", 0);
    now_a("minus", 0, 1);
    chk("minus.b.out", int'(out_b), 1);
    pulse_clr();
    send_str("3 + 4", 0);
    now_a("space", 1, 0);
    pulse_clr();
    send_str("3+", 1);
    now_a("gaps", 0, 0);
    pulse_clr();
    send_str("(1+", 0);
    pulse_clr();
    send_str("5", 0);
    now_a("after_clr", 1, 0);
    pulse_clr();
    send_str(")", 0);
    now_a("rp0", 0, 1);
    pulse_clr();

    pool = "0123456789012345+*-/(()) x";
    for (int i = 0; i < 600; i++) begin
      byte c;
      c = pool[$urandom_range(0, pool.len() - 1)];
      send(c, $urandom_range(0, 7) != 0);
      if ($urandom_range(0, 24) == 0) pulse_clr();
    end

    repeat (3) @(negedge clk);
    #1;
    chk("sb.drain", sb_a.size() + sb_b.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
